// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   state_t      : loader FSM states
//   ICNT_LSB     : bit position of the instruction word count in the header
//   DCNT_LSB     : bit position of the data doubleword count in the header
//   IMEM_STRIDE  : byte stride between instruction memory words
//   DMEM_STRIDE  : byte stride between data memory doublewords
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        IMEM    = 3'd2,
        DMEM_LO = 3'd3,
        DMEM_HI = 3'd4,
        RUN     = 3'd5,
        ERR     = 3'd6
    } state_t;

    localparam int ICNT_LSB    = 0;
    localparam int DCNT_LSB    = 16;
    localparam int IMEM_STRIDE = 4;
    localparam int DMEM_STRIDE = 8;

endpackage

// File: rtl/program_loader_write.sv
// Registered memory write port generator.
// A request on i_we produces a single-cycle o_wen pulse in the next cycle with
// o_addr = i_index * STRIDE and o_wdata = i_data. Address and data read as 0
// whenever no write is being issued.
//   clk, arst : clock, asynchronous active-high reset
//   i_we      : write request (one cycle per word)
//   i_index   : word index within the memory
//   i_data    : word to write
//   o_addr    : byte address
//   o_wen     : write enable pulse
//   o_wdata   : write data
module loader_write_port #(
    parameter int DATA_W = 32,
    parameter int STRIDE = 4,
    parameter int IDX_W  = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [DATA_W-1:0] i_data,
    output logic [63:0]       o_addr,
    output logic              o_wen,
    output logic [DATA_W-1:0] o_wdata
);

    logic [63:0]       r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
        end else if (i_we) begin
            r_addr  <= 64'(i_index) * 64'(STRIDE);
            r_wen   <= 1'b1;
            r_wdata <= i_data;
        end else begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
        end
    end

    assign o_addr  = r_addr;
    assign o_wen   = r_wen;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader placed in front of the cpu top.
// Consumes a valid/ready stream: a header word {dcnt, icnt}, icnt instruction
// words, then dcnt doublewords sent low half first. Writes both images into
// memory and then starts the cpu.
//   clk, arst            : clock, asynchronous active-high reset
//   start                : one-cycle pulse that begins a load
//   s_valid/s_ready/s_data : input word stream
//   addr_ext/wen_ext/ren_ext/wdata_ext         : instruction memory port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2 : data memory port
//   cpu_enable, done     : load complete, cpu running
//   busy                 : load in progress
//   error                : header rejected
//
// state   | meaning
// IDLE    | waiting for start after reset
// HEADER  | waiting for the header word
// IMEM    | streaming instruction words
// DMEM_LO | waiting for the low half of a data doubleword
// DMEM_HI | waiting for the high half; completes the doubleword
// RUN     | load done, cpu enabled until reset
// ERR     | header counts exceeded memory depth; start retries
module program_loader
    import program_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [CNT_W-1:0] IMEM_LIM = CNT_W'(IMEM_DEPTH);
    localparam logic [CNT_W-1:0] DMEM_LIM = CNT_W'(DMEM_DEPTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_icnt;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] r_kcnt;
    logic [CNT_W-1:0] r_jcnt;
    logic [31:0]      r_low;
    logic             r_run;

    logic             w_ready;
    logic             w_busy;
    logic             w_error;
    logic             w_xfer;
    logic             w_imem_we;
    logic             w_dmem_we;
    logic [CNT_W-1:0] w_hdr_icnt;
    logic [CNT_W-1:0] w_hdr_dcnt;
    logic             w_i_last;
    logic             w_j_last;

    assign w_hdr_icnt = s_data[ICNT_LSB +: CNT_W];
    assign w_hdr_dcnt = s_data[DCNT_LSB +: CNT_W];
    assign w_xfer     = s_valid & w_ready;
    // Header check bounds the counts, so index + 1 never wraps.
    assign w_i_last   = ((r_kcnt + ONE) == r_icnt);
    assign w_j_last   = ((r_jcnt + ONE) == r_dcnt);

    // State register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = HEADER;
            end
            HEADER: begin
                if (w_xfer) begin
                    if (w_hdr_icnt > IMEM_LIM || w_hdr_dcnt > DMEM_LIM)
                        w_next = ERR;
                    else if (w_hdr_icnt != '0)
                        w_next = IMEM;
                    else if (w_hdr_dcnt != '0)
                        w_next = DMEM_LO;
                    else
                        w_next = RUN;
                end
            end
            IMEM: begin
                if (w_xfer && w_i_last)
                    w_next = (r_dcnt != '0) ? DMEM_LO : RUN;
            end
            DMEM_LO: begin
                if (w_xfer) w_next = DMEM_HI;
            end
            DMEM_HI: begin
                if (w_xfer) w_next = w_j_last ? RUN : DMEM_LO;
            end
            RUN: begin
                w_next = RUN;
            end
            ERR: begin
                if (start) w_next = HEADER;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        w_ready   = 1'b0;
        w_busy    = 1'b0;
        w_error   = 1'b0;
        case (r_state)
            HEADER, IMEM, DMEM_LO, DMEM_HI: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
            ERR: begin
                w_error = 1'b1;
            end
            default: begin
            end
        endcase
        w_imem_we = w_xfer && (r_state == IMEM);
        w_dmem_we = w_xfer && (r_state == DMEM_HI);
    end

    // Header fields, word indices and the pending low half
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_icnt <= '0;
            r_dcnt <= '0;
            r_kcnt <= '0;
            r_jcnt <= '0;
            r_low  <= '0;
            r_run  <= 1'b0;
        end else begin
            // Registered from RUN so the cpu starts one cycle after the last write pulse.
            r_run <= (r_state == RUN);
            if (w_xfer) begin
                case (r_state)
                    HEADER: begin
                        r_icnt <= w_hdr_icnt;
                        r_dcnt <= w_hdr_dcnt;
                        r_kcnt <= '0;
                        r_jcnt <= '0;
                    end
                    IMEM:    r_kcnt <= r_kcnt + ONE;
                    DMEM_LO: r_low  <= s_data;
                    DMEM_HI: r_jcnt <= r_jcnt + ONE;
                    default: begin
                    end
                endcase
            end
        end
    end

    loader_write_port #(
        .DATA_W (32),
        .STRIDE (IMEM_STRIDE),
        .IDX_W  (CNT_W)
    ) u_imem_port (
        .clk     (clk),
        .arst    (arst),
        .i_we    (w_imem_we),
        .i_index (r_kcnt),
        .i_data  (s_data),
        .o_addr  (addr_ext),
        .o_wen   (wen_ext),
        .o_wdata (wdata_ext)
    );

    loader_write_port #(
        .DATA_W (64),
        .STRIDE (DMEM_STRIDE),
        .IDX_W  (CNT_W)
    ) u_dmem_port (
        .clk     (clk),
        .arst    (arst),
        .i_we    (w_dmem_we),
        .i_index (r_jcnt),
        .i_data  ({s_data, r_low}),
        .o_addr  (addr_ext_2),
        .o_wen   (wen_ext_2),
        .o_wdata (wdata_ext_2)
    );

    assign s_ready    = w_ready;
    assign busy       = w_busy;
    assign error      = w_error;
    assign cpu_enable = r_run;
    assign done       = r_run;
    assign ren_ext    = 1'b0;
    assign ren_ext_2  = 1'b0;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Inputs change 1 ns after the rising edge,
// outputs are read at that point; write pulses are logged on the falling edge.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [63:0] im_addr[$];
    logic [31:0] im_data[$];
    logic [63:0] dm_addr[$];
    logic [63:0] dm_data[$];

    program_loader dut (
        .clk         (clk),
        .arst        (arst),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wen_ext) begin
            im_addr.push_back(addr_ext);
            im_data.push_back(wdata_ext);
        end
        if (wen_ext_2) begin
            dm_addr.push_back(addr_ext_2);
            dm_data.push_back(wdata_ext_2);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        im_addr.delete();
        im_data.delete();
        dm_addr.delete();
        dm_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) step();
    endtask

    // Presents one word and returns 1 ns after the edge on which it transfers.
    task automatic send(input logic [31:0] d);
        bit ok;
        bit rdy;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int n = 0; n < 200; n++) begin
            rdy = s_ready;
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=no_xfer expected=xfer data=%h", d);
        end
    endtask

    task automatic do_reset();
        arst = 1'b1;
        step();
        step();
        arst = 1'b0;
        clear_logs();
        step();
    endtask

    // Expected writes for header 0x0002_0003 with A,B,C and 1,2,3,4.
    task automatic check_basic_logs(input string tag);
        check({tag, "_im_n"}, 64'(im_addr.size()), 64'd3);
        check({tag, "_im0_a"}, im_addr[0], 64'h0);
        check({tag, "_im0_d"}, 64'(im_data[0]), 64'hA);
        check({tag, "_im1_a"}, im_addr[1], 64'h4);
        check({tag, "_im1_d"}, 64'(im_data[1]), 64'hB);
        check({tag, "_im2_a"}, im_addr[2], 64'h8);
        check({tag, "_im2_d"}, 64'(im_data[2]), 64'hC);
        check({tag, "_dm_n"}, 64'(dm_addr.size()), 64'd2);
        check({tag, "_dm0_a"}, dm_addr[0], 64'h0);
        check({tag, "_dm0_d"}, dm_data[0], 64'h0000_0002_0000_0001);
        check({tag, "_dm1_a"}, dm_addr[1], 64'h8);
        check({tag, "_dm1_d"}, dm_data[1], 64'h0000_0004_0000_0003);
    endtask

    initial begin
        arst    = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        step();
        step();

        // Reset state
        check("rst_cpu_enable", cpu_enable, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_wen", wen_ext, 0);
        check("rst_wen2", wen_ext_2, 0);
        check("rst_addr", addr_ext, 0);
        check("rst_wdata2", wdata_ext_2, 0);
        check("rst_ren", ren_ext, 0);
        check("rst_ren2", ren_ext_2, 0);
        arst = 1'b0;
        step();
        check("idle_ready", s_ready, 0);

        // Scenario 1: full load, no gaps
        pulse_start();
        check("s1_busy", busy, 1);
        check("s1_ready", s_ready, 1);
        send(32'h0002_0003);
        send(32'hA);
        send(32'hB);
        send(32'hC);
        check("s1_wen_C", wen_ext, 1);
        check("s1_addr_C", addr_ext, 64'h8);
        send(32'h1);
        send(32'h2);
        send(32'h3);
        send(32'h4);
        check("s1_wen2_last", wen_ext_2, 1);
        check("s1_cpu_en_early", cpu_enable, 0);
        step();
        check("s1_cpu_en", cpu_enable, 1);
        check("s1_done", done, 1);
        check("s1_busy_run", busy, 0);
        check("s1_wen2_after", wen_ext_2, 0);
        check("s1_addr2_idle", addr_ext_2, 0);
        check_basic_logs("s1");
        do_reset();
        check("s1_reset_cpu_en", cpu_enable, 0);

        // Scenario 2: empty images
        pulse_start();
        send(32'h0000_0000);
        check("s2_cpu_en_1", cpu_enable, 0);
        step();
        check("s2_cpu_en_2", cpu_enable, 1);
        check("s2_writes", 64'(im_addr.size() + dm_addr.size()), 0);
        do_reset();

        // Scenario 3: oversize header, then retry
        pulse_start();
        send(32'h0000_0201);
        check("s3_error", error, 1);
        check("s3_ready", s_ready, 0);
        check("s3_busy", busy, 0);
        s_valid = 1'b1;
        s_data  = 32'h1234;
        step();
        step();
        s_valid = 1'b0;
        check("s3_no_writes", 64'(im_addr.size() + dm_addr.size()), 0);
        check("s3_error_held", error, 1);
        pulse_start();
        check("s3_error_clr", error, 0);
        check("s3_ready_hdr", s_ready, 1);
        send(32'h0000_0001);
        send(32'h13);
        check("s3_wen", wen_ext, 1);
        check("s3_addr", addr_ext, 0);
        check("s3_wdata", 64'(wdata_ext), 64'h13);
        step();
        check("s3_cpu_en", cpu_enable, 1);
        check("s3_error_run", error, 0);
        do_reset();

        // Scenario 4: gaps in s_valid, including between low and high halves
        pulse_start();
        idle(2);
        send(32'h0002_0003);
        idle(1);
        send(32'hA);
        send(32'hB);
        idle(3);
        send(32'hC);
        send(32'h1);
        idle(4);
        check("s4_gap_ready", s_ready, 1);
        check("s4_gap_wen2", wen_ext_2, 0);
        check("s4_gap_busy", busy, 1);
        send(32'h2);
        send(32'h3);
        idle(2);
        send(32'h4);
        step();
        check("s4_cpu_en", cpu_enable, 1);
        check_basic_logs("s4");
        do_reset();

        // Scenario 5: reset in the middle of the instruction image
        pulse_start();
        send(32'h0002_0003);
        send(32'hA);
        send(32'hB);
        arst = 1'b1;
        #1;
        check("s5_wen_rst", wen_ext, 0);
        check("s5_addr_rst", addr_ext, 0);
        check("s5_wdata_rst", 64'(wdata_ext), 0);
        check("s5_busy_rst", busy, 0);
        check("s5_ready_rst", s_ready, 0);
        s_valid = 1'b1;
        s_data  = 32'hC;
        step();
        step();
        arst = 1'b0;
        step();
        step();
        step();
        s_valid = 1'b0;
        check("s5_im_n", 64'(im_addr.size()), 1);
        check("s5_im0_d", 64'(im_data[0]), 64'hA);
        check("s5_cpu_en", cpu_enable, 0);
        clear_logs();
        pulse_start();
        send(32'h0001_0001);
        send(32'h55);
        send(32'h7);
        send(32'h8);
        step();
        check("s5b_cpu_en", cpu_enable, 1);
        check("s5b_im_n", 64'(im_addr.size()), 1);
        check("s5b_im0_d", 64'(im_data[0]), 64'h55);
        check("s5b_dm_n", 64'(dm_addr.size()), 1);
        check("s5b_dm0_a", dm_addr[0], 0);
        check("s5b_dm0_d", dm_data[0], 64'h0000_0008_0000_0007);
        do_reset();

        // Scenario 6: full instruction memory, start pulses ignored
        pulse_start();
        send(32'h0000_0200);
        for (int i = 0; i < 512; i++) begin
            start = (i == 3 || i == 200);
            send(32'(i) ^ 32'h5A00_0000);
            start = 1'b0;
        end
        check("s6_wen_last", wen_ext, 1);
        check("s6_addr_last", addr_ext, 64'h7FC);
        check("s6_data_last", 64'(wdata_ext), 64'h5A00_01FF);
        step();
        check("s6_cpu_en", cpu_enable, 1);
        check("s6_im_n", 64'(im_addr.size()), 512);
        check("s6_im300_a", im_addr[300], 64'd1200);
        check("s6_im300_d", 64'(im_data[300]), 64'h5A00_012C);
        check("s6_dm_n", 64'(dm_addr.size()), 0);
        pulse_start();
        step();
        check("s6_run_cpu_en", cpu_enable, 1);
        check("s6_run_busy", busy, 0);
        check("s6_run_ready", s_ready, 0);
        check("s6_run_done", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
